// File: rtl/instr_cache_sa.sv
// N-way set-associative instruction cache with its own single-beat block refill,
// global invalidate and misaligned-fetch flag. A refilled line is forwarded to the fetch during FILL.

module instr_cache_sa_way #(
  parameter int TAG_W     = 24,
  parameter int WORDS     = 16,
  parameter int WORD_SIZE = 32,
  parameter int WOFF_W    = 4
) (
  input  logic                             vld,
  input  logic [TAG_W-1:0]                 tag,
  input  logic [TAG_W-1:0]                 req_tag,
  input  logic [WORDS-1:0][WORD_SIZE-1:0]  line,
  input  logic [WOFF_W-1:0]                woff,
  output logic                             hit,
  output logic [WORD_SIZE-1:0]             word
);
  assign hit  = vld && (tag == req_tag);
  assign word = line[woff];
endmodule

module instr_cache_sa #(
  parameter int BLOCK_COUNT = 4,
  parameter int WAYS        = 2,
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_WIDTH = 512,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   i_req,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic                   i_invalidate,
  output logic                   o_valid,
  output logic [WORD_SIZE-1:0]   o_instr,
  output logic                   o_instr_addr_ma,
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_valid,
  input  logic [BLOCK_WIDTH-1:0] i_mem_data
);
  localparam int BOW   = $clog2(WORD_SIZE/8);
  localparam int WORDS = BLOCK_WIDTH/WORD_SIZE;
  localparam int WOW   = $clog2(WORDS);
  localparam int IW    = $clog2(BLOCK_COUNT);
  localparam int TAG_W = ADDR_WIDTH - IW - WOW - BOW;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [WORDS-1:0][WORD_SIZE-1:0] line_t;
  typedef enum logic [1:0] {IDLE, REFILL, FILL} state_t;

  state_t                                  state_q;
  logic [BLOCK_COUNT-1:0][WAYS-1:0][TAG_W-1:0] tag_q;
  line_t [BLOCK_COUNT-1:0][WAYS-1:0]       line_q;
  logic [BLOCK_COUNT-1:0][WAYS-1:0]        valid_q;
  logic [BLOCK_COUNT-1:0][WAY_W-1:0]       rr_q;

  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [IW-1:0]         idx_q;
  logic [WOW-1:0]        woff_q;
  logic [TAG_W-1:0]      fill_tag_q;
  logic [WAY_W-1:0]      vic_q;
  logic                  vic_rr_q;
  logic                  pend_inv_q;
  line_t                 fill_line_q;

  logic [TAG_W-1:0] req_tag;
  logic [IW-1:0]    req_idx;
  logic [WOW-1:0]   req_woff;
  logic             ma;
  assign req_tag  = i_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx  = i_addr[BOW+WOW +: IW];
  assign req_woff = i_addr[BOW +: WOW];
  assign ma       = |i_addr[BOW-1:0];

  logic [WAYS-1:0]                 hit_vec;
  logic [WAYS-1:0][WORD_SIZE-1:0]  word_vec;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    instr_cache_sa_way #(
      .TAG_W(TAG_W), .WORDS(WORDS), .WORD_SIZE(WORD_SIZE), .WOFF_W(WOW)
    ) u_way (
      .vld     (valid_q[req_idx][w]),
      .tag     (tag_q[req_idx][w]),
      .req_tag (req_tag),
      .line    (line_q[req_idx][w]),
      .woff    (req_woff),
      .hit     (hit_vec[w]),
      .word    (word_vec[w])
    );
  end

  logic                 hit;
  logic [WORD_SIZE-1:0] hit_word;
  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) begin
        hit      = 1'b1;
        hit_word = hit_word | word_vec[w];
      end
  end

  // lowest invalid way wins; round-robin only when the set is full
  logic [WAY_W-1:0] vic_way;
  logic             vic_rr;
  always_comb begin
    vic_way = rr_q[req_idx];
    vic_rr  = 1'b1;
    for (int w = WAYS-1; w >= 0; w--)
      if (!valid_q[req_idx][w]) begin
        vic_way = WAY_W'(w);
        vic_rr  = 1'b0;
      end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      idx_q       <= '0;
      woff_q      <= '0;
      fill_tag_q  <= '0;
      vic_q       <= '0;
      vic_rr_q    <= 1'b0;
      pend_inv_q  <= 1'b0;
      fill_line_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_req && !ma && !hit) begin
          state_q    <= REFILL;
          mem_req_q  <= 1'b1;
          mem_addr_q <= {i_addr[ADDR_WIDTH-1:BOW+WOW], {(BOW+WOW){1'b0}}};
          idx_q      <= req_idx;
          woff_q     <= req_woff;
          fill_tag_q <= req_tag;
          vic_q      <= vic_way;
          vic_rr_q   <= vic_rr;
          pend_inv_q <= 1'b0;
        end
        REFILL: begin
          if (i_invalidate) pend_inv_q <= 1'b1;
          if (i_mem_valid) begin
            fill_line_q <= i_mem_data;
            mem_req_q   <= 1'b0;
            state_q     <= FILL;
          end
        end
        FILL: begin
          state_q    <= IDLE;
          pend_inv_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tag_q   <= '0;
      line_q  <= '0;
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      if (state_q == FILL) begin
        tag_q[idx_q][vic_q]  <= fill_tag_q;
        line_q[idx_q][vic_q] <= fill_line_q;
        if (vic_rr_q)
          rr_q[idx_q] <= (rr_q[idx_q] == WAY_W'(WAYS-1)) ? '0 : rr_q[idx_q] + WAY_W'(1);
      end
      // an invalidate seen during the refill (or in FILL itself) leaves the new line invalid
      if (i_invalidate)
        valid_q <= '0;
      else if (state_q == FILL && !pend_inv_q)
        valid_q[idx_q][vic_q] <= 1'b1;
    end
  end

  always_comb begin
    o_valid = 1'b0;
    o_instr = '0;
    if (state_q == IDLE && i_req) begin
      if (ma)
        o_valid = 1'b1;
      else if (hit) begin
        o_valid = 1'b1;
        o_instr = hit_word;
      end
    end else if (state_q == FILL && i_req) begin
      o_valid = 1'b1;
      o_instr = fill_line_q[woff_q];
    end
  end

  assign o_instr_addr_ma = ma;
  assign o_mem_req       = mem_req_q;
  assign o_mem_addr      = mem_addr_q;
endmodule

// File: tb/tb_instr_cache_sa.sv
// Directed bench for instr_cache_sa: cold miss, replacement, invalidate, misaligned, reset mid-refill.

module tb_instr_cache_sa;
  logic         clk = 1'b0;
  logic         arstn;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_invalidate;
  logic         o_valid;
  logic [31:0]  o_instr;
  logic         o_instr_addr_ma;
  logic         o_mem_req;
  logic [31:0]  o_mem_addr;
  logic         i_mem_valid;
  logic [511:0] i_mem_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_cache_sa #(
    .BLOCK_COUNT(4), .WAYS(2), .WORD_SIZE(32), .BLOCK_WIDTH(512), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .arstn(arstn), .i_req(i_req), .i_addr(i_addr), .i_invalidate(i_invalidate),
    .o_valid(o_valid), .o_instr(o_instr), .o_instr_addr_ma(o_instr_addr_ma),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data)
  );

  function automatic logic [511:0] line_pat();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    return d;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    arstn = 1'b0; i_req = 1'b0; i_addr = '0; i_invalidate = 1'b0;
    i_mem_valid = 1'b0; i_mem_data = line_pat();
    @(posedge clk); #1;
    arstn = 1'b1;
  endtask

  // Drives one fetch from posedge+1; serves a miss with latency lat, optionally pulsing
  // i_invalidate in the first REFILL cycle. Returns at posedge+1 with i_req low.
  task automatic fetch(input logic [31:0] addr, input int lat, input logic inv,
                       output logic hit, output logic [31:0] hinst,
                       output logic req_ok, output logic [31:0] maddr,
                       output logic vf, output logic [31:0] finst);
    i_req = 1'b1; i_addr = addr;
    #1;
    hit = o_valid; hinst = o_instr;
    req_ok = 1'b1; maddr = '0; vf = 1'b0; finst = '0;
    if (hit) begin
      @(posedge clk); #1;
      i_req = 1'b0;
      return;
    end
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk); #1;
      i_invalidate = inv && (k == 0);
      i_mem_valid  = (k == lat);
      #1;
      req_ok = req_ok && (o_mem_req === 1'b1) && (o_valid === 1'b0);
      maddr  = o_mem_addr;
    end
    @(posedge clk); #1;
    i_mem_valid = 1'b0; i_invalidate = 1'b0;
    #1;
    vf = o_valid; finst = o_instr;
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    arstn = 1'b0; i_req = 1'b0; i_addr = '0; i_invalidate = 1'b0;
    i_mem_valid = 1'b0; i_mem_data = line_pat();
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", o_mem_req); end
    total++; if (o_mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", o_mem_addr); end
    total++; if (o_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", o_instr); end
    @(posedge clk); #1;
    arstn = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic h, rq, vf; logic [31:0] hi, ma, fi;
    do_reset();
    fetch(32'h104, 3, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0) begin bad++; $display("FAIL cold_miss_t got=%b exp=0", h); end
    total++; if (rq !== 1'b1) begin bad++; $display("FAIL cold_mem_req_window got=%b exp=1", rq); end
    total++; if (ma !== 32'h100) begin bad++; $display("FAIL cold_mem_addr got=%h exp=00000100", ma); end
    total++; if (vf !== 1'b1 || fi !== 32'hA000_0001) begin bad++; $display("FAIL cold_fwd got=%b/%h exp=1/a0000001", vf, fi); end
    fetch(32'h108, 3, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b1 || hi !== 32'hA000_0002) begin bad++; $display("FAIL cold_rehit got=%b/%h exp=1/a0000002", h, hi); end
  endtask

  task automatic test_replace();
    logic h, rq, vf; logic [31:0] hi, ma, fi;
    do_reset();
    fetch(32'h004, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0 || vf !== 1'b1 || fi !== 32'hA000_0001) begin bad++; $display("FAIL repl_fill004 got=%b/%b/%h exp=0/1/a0000001", h, vf, fi); end
    fetch(32'h104, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0) begin bad++; $display("FAIL repl_fill104 got=%b exp=0", h); end
    fetch(32'h004, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b1) begin bad++; $display("FAIL repl_both_resident got=%b exp=1", h); end
    fetch(32'h204, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0 || ma !== 32'h200) begin bad++; $display("FAIL repl_fill204 got=%b/%h exp=0/00000200", h, ma); end
    fetch(32'h104, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b1 || hi !== 32'hA000_0001) begin bad++; $display("FAIL repl_104_kept got=%b/%h exp=1/a0000001", h, hi); end
    fetch(32'h004, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0) begin bad++; $display("FAIL repl_004_evicted got=%b exp=0", h); end
    fetch(32'h204, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b1) begin bad++; $display("FAIL repl_204_kept got=%b exp=1", h); end
    fetch(32'h104, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0) begin bad++; $display("FAIL repl_104_evicted_by_rr got=%b exp=0", h); end
  endtask

  task automatic test_invalidate();
    logic h, rq, vf; logic [31:0] hi, ma, fi;
    do_reset();
    fetch(32'h000, 1, 1'b0, h, hi, rq, ma, vf, fi);
    fetch(32'h040, 1, 1'b0, h, hi, rq, ma, vf, fi);
    fetch(32'h040, 1, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b1) begin bad++; $display("FAIL inv_pre_hit got=%b exp=1", h); end
    i_req = 1'b1; i_addr = 32'h000; i_invalidate = 1'b1;
    #1;
    total++; if (o_valid !== 1'b1 || o_instr !== 32'hA000_0000) begin bad++; $display("FAIL inv_same_cycle_hit got=%b/%h exp=1/a0000000", o_valid, o_instr); end
    @(posedge clk); #1;
    i_req = 1'b0; i_invalidate = 1'b0;
    fetch(32'h000, 1, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0 || rq !== 1'b1 || ma !== 32'h000) begin bad++; $display("FAIL inv_miss000 got=%b/%b/%h exp=0/1/00000000", h, rq, ma); end
    fetch(32'h040, 1, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0 || rq !== 1'b1 || ma !== 32'h040) begin bad++; $display("FAIL inv_miss040 got=%b/%b/%h exp=0/1/00000040", h, rq, ma); end
  endtask

  task automatic test_misaligned();
    do_reset();
    i_req = 1'b1; i_addr = 32'h106;
    #1;
    total++; if (o_valid !== 1'b1 || o_instr_addr_ma !== 1'b1 || o_instr !== 32'h0) begin bad++; $display("FAIL ma_resp got=%b/%b/%h exp=1/1/00000000", o_valid, o_instr_addr_ma, o_instr); end
    @(posedge clk); #1;
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL ma_no_refill got=%b exp=0", o_mem_req); end
    i_req = 1'b0; i_addr = 32'h104;
    #1;
    total++; if (o_instr_addr_ma !== 1'b0) begin bad++; $display("FAIL ma_aligned got=%b exp=0", o_instr_addr_ma); end
  endtask

  task automatic test_inv_mid_refill();
    logic h, rq, vf; logic [31:0] hi, ma, fi;
    do_reset();
    fetch(32'h100, 3, 1'b1, h, hi, rq, ma, vf, fi);
    total++; if (vf !== 1'b1 || fi !== 32'hA000_0000) begin bad++; $display("FAIL invmid_fwd got=%b/%h exp=1/a0000000", vf, fi); end
    fetch(32'h100, 3, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0 || rq !== 1'b1) begin bad++; $display("FAIL invmid_remiss got=%b/%b exp=0/1", h, rq); end
    fetch(32'h100, 3, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b1) begin bad++; $display("FAIL invmid_then_hit got=%b exp=1", h); end
  endtask

  task automatic test_reset_mid_refill();
    logic h, rq, vf; logic [31:0] hi, ma, fi;
    do_reset();
    fetch(32'h104, 1, 1'b0, h, hi, rq, ma, vf, fi);
    i_req = 1'b1; i_addr = 32'h300;
    @(posedge clk); #1;
    total++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h300) begin bad++; $display("FAIL rstmid_req got=%b/%h exp=1/00000300", o_mem_req, o_mem_addr); end
    arstn = 1'b0; i_req = 1'b0;
    #1;
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_async_drop got=%b exp=0", o_mem_req); end
    @(posedge clk); #1;
    arstn = 1'b1; i_mem_valid = 1'b1;
    @(posedge clk); #1;
    i_mem_valid = 1'b0;
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_late_beat got=%b exp=0", o_mem_req); end
    fetch(32'h300, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0 || rq !== 1'b1) begin bad++; $display("FAIL rstmid_remiss got=%b/%b exp=0/1", h, rq); end
    fetch(32'h104, 2, 1'b0, h, hi, rq, ma, vf, fi);
    total++; if (h !== 1'b0) begin bad++; $display("FAIL rstmid_lines_cleared got=%b exp=0", h); end
  endtask

  initial begin
    arstn = 1'b0; i_req = 1'b0; i_addr = '0; i_invalidate = 1'b0;
    i_mem_valid = 1'b0; i_mem_data = '0;
    test_reset();
    test_cold_miss();
    test_replace();
    test_invalidate();
    test_misaligned();
    test_inv_mid_refill();
    test_reset_mid_refill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_cache_sa.md
# instr_cache_sa

Parametrised N-way set-associative instruction cache that replaces the direct-mapped, externally-filled instruction cache in the fetch stage. It owns its own refill: on a miss it issues a block-aligned request to the memory side, waits for one full-block response, installs the line in a victim way (first invalid way, else per-set round-robin), then serves the fetch. It also provides fence.i-style invalidation and a misaligned-fetch flag. The block sits between the fetch stage and the memory/bus adapter.

## Interface

Parameters:
- BLOCK_COUNT, 4, number of sets; power of 2, ≥2
- WAYS, 2, associativity; power of 2, ≥1 (1 gives direct-mapped)
- WORD_SIZE, 32, instruction word width
- BLOCK_WIDTH, 512, line width; power-of-2 multiple of WORD_SIZE
- ADDR_WIDTH, 32, byte address width

Derived widths:
- BYTE_OFFSET_W = clog2(WORD_SIZE/8)
- WORD_OFFSET_W = clog2(BLOCK_WIDTH/WORD_SIZE)
- INDEX_W = clog2(BLOCK_COUNT)
- TAG_W = ADDR_WIDTH − INDEX_W − WORD_OFFSET_W − BYTE_OFFSET_W

Ports:
- clk  in  1  single clock, rising edge
- arstn  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; i_addr is held stable until o_valid
- i_addr  in  ADDR_WIDTH  fetch byte address
- i_invalidate  in  1  one-cycle pulse; clears every valid bit
- o_valid  out  1  response for the current request
- o_instr  out  WORD_SIZE  instruction word; valid only with o_valid
- o_instr_addr_ma  out  1  misaligned fetch, i.e. OR of i_addr[BYTE_OFFSET_W−1:0]
- o_mem_req  out  1  refill request; held until i_mem_valid
- o_mem_addr  out  ADDR_WIDTH  block-aligned refill address; low offset bits are 0
- i_mem_valid  in  1  refill data beat; single beat carries the whole line
- i_mem_data  in  BLOCK_WIDTH  refill line; word 0 is in bits [WORD_SIZE−1:0]

## Operation

- Arrays:
  - tag[set][way], line[set][way] and valid[set][way].
  - rr_ptr[set], WAYS-wide modulo counter.
  - All arrays and counters are cleared on reset.
- States:
  - IDLE: lookup.
  - REFILL: o_mem_req=1, waiting for i_mem_valid.
  - FILL: write line.
- IDLE with i_req:
  - Misaligned: o_valid=1 and o_instr_addr_ma=1 in the same cycle. o_instr='0. No refill.
  - Hit (any way with valid and tag equal): o_valid=1 in the same cycle. o_instr is the word selected by the word offset from the hitting way. Stay in IDLE.
  - Miss: o_valid=0. Latch the block address and the victim way, then go to REFILL.
- Victim choice: the lowest-index invalid way in the set; if all ways are valid, rr_ptr[set].
- REFILL:
  - o_mem_req=1 and o_mem_addr stable.
  - On i_mem_valid, capture i_mem_data and go to FILL.
- FILL:
  - Write tag and line into the latched victim.
  - Set valid, unless an invalidate arrived after the miss (see boundaries).
  - If the victim came from rr_ptr, advance rr_ptr[set] modulo WAYS.
  - Return to IDLE. The next cycle re-looks up and hits.
- i_invalidate:
  - Clears all valid bits in the cycle it is sampled.
  - rr_ptr, tags and data are unchanged.
- Boundaries:
  - Invalidate together with a hit in IDLE: this cycle's response is still delivered; valid bits are cleared at the clock edge.
  - Invalidate while in REFILL or FILL: a pending-invalidate flag is set.
    - FILL writes the line but leaves it invalid.
    - The request is served by a one-cycle forwarded response: o_valid=1 in FILL from the captured line.
    - The flag clears on return to IDLE.
  - Invalidate in FILL uses the same behaviour.
  - Rule for every refill: the requesting fetch gets o_valid in FILL (forwarded). A forwarded fetch must not re-look up in IDLE.
  - i_mem_valid outside REFILL is ignored.
  - i_req dropped during REFILL or FILL: the refill completes and the line is installed; no o_valid.
  - Reset mid-refill: immediately returns to IDLE. o_mem_req drops asynchronously. All lines are invalid.
  - WAYS=1: rr_ptr is unused and the victim is always way 0.

## Timing

- Reset values: o_valid=0, o_mem_req=0, o_mem_addr='0, o_instr='0. o_instr_addr_ma follows i_addr combinationally.
- Hit latency: 0 cycles, combinational from i_addr.
- Miss:
  - Miss seen in cycle t.
  - o_mem_req=1 from t+1.
  - i_mem_valid in cycle t+1+L.
  - FILL and o_valid forwarded in t+2+L.
  - Back to IDLE in t+3+L.
- A back-to-back hit to the same line is accepted in t+3+L.
- o_mem_addr, o_mem_req and the state are registered. o_valid and o_instr are combinational from the state, the arrays and i_addr.

## Test plan

Configuration for all scenarios: WAYS=2, BLOCK_COUNT=4, BLOCK_WIDTH=512, ADDR_WIDTH=32. Line data pattern: word k = 0xA000_0000+k.

1. Cold miss:
   - After reset, i_req with i_addr=0x104, memory latency L=3.
   - o_valid=0 at t. o_mem_req=1 with o_mem_addr=0x100 over t+1..t+4.
   - o_valid=1 with o_instr=0xA000_0001 at t+5.
   - Re-request of 0x108 hits with 0 latency and returns 0xA000_0002.
2. Replacement:
   - Fill 0x004 (way 0), then 0x104 (way 1), then 0x204.
   - 0x204 evicts way 0 and rr_ptr[0] becomes 1.
   - 0x104 then hits; 0x004 misses and evicts way 1.
3. Invalidate:
   - Lines 0x000 and 0x040 are present; pulse i_invalidate.
   - The next requests to 0x000 and 0x040 both miss and raise o_mem_req.
4. Misaligned fetch:
   - i_addr=0x106.
   - Same-cycle o_valid=1, o_instr_addr_ma=1, o_instr=0. o_mem_req stays 0.
5. Invalidate mid-refill:
   - Pulse i_invalidate while in REFILL for 0x100.
   - o_valid=1 in FILL with the correct word.
   - The immediate re-request of 0x100 misses again.
6. Reset mid-refill:
   - Drop arstn while o_mem_req=1.
   - o_mem_req goes to 0 immediately.
   - A late i_mem_valid is ignored; the next request to the same address misses.
